seq_det_10010: RTL and testbench
================================

// Module: seq_det_10010
// PURPOSE
//  Serial "10010" sequence detector on a 1-bit input stream, sampled on each rising clk edge.
//  One RTL body covers both machine styles, chosen by the MOORE parameter:
//  - Mealy style: the detect output depends on state and input.
//  - Moore style: the detect output depends on state only.
//  Sits at the leaf level of a serial-protocol front end. Two instances (one per style) can run side by side for equivalence comparison.
// PARAMETERS
//  MOORE    1  1 = Moore machine (6 states, registered-state output); 0 = Mealy machine (5 states)
//  OVERLAP  1  1 = overlapping detection (suffix reused); 0 = restart from idle after each detect
//  CNT_W    8  width of match counter (only with SEQ_DET_COUNT_EN)
// PORTS
//  clk    in   1      clock; all state updates on rising edge
//  rst    in   1      reset; asynchronous, active-low (rst=0 forces reset immediately)
//  j      in   1      serial data bit, sampled at posedge clk
//  w      out  1      detect flag
//  count  out  CNT_W  saturating number of detections (only with SEQ_DET_COUNT_EN)
// BEHAVIOUR
//  - States (name = longest matched prefix of the sequence):
//    S0 ""  S1 "1"  S2 "10"  S3 "100"  S4 "1001"  S5 "10010" (S5 exists in Moore only)
//  - Reset: state=S0, w=0, count=0. Takes effect immediately, independent of clk.
//    Reset asserted mid-sequence discards all partial matches.
//  - Transitions on posedge clk (j=0 / j=1):
//    S0 -> S0 / S1
//    S1 -> S2 / S1
//    S2 -> S3 / S1
//    S3 -> S0 / S4
//    S4 -> DET / S1
//  - DET depends on style and overlap:
//    Moore: DET = S5.
//    Mealy, OVERLAP=1: DET = S2.
//    Mealy, OVERLAP=0: DET = S0.
//  - Moore S5 exits:
//    OVERLAP=1: S3 / S1 (behaves as S2 for the next bit).
//    OVERLAP=0: S0 / S1.
//  - Mealy output: w = (state==S4) & ~j.
//    Purely combinational; asserts during the cycle in which the final 0 is present on j.
//  - Moore output: w = (state==S5).
//    Asserts exactly one full clock cycle, starting one edge after the final 0 is sampled.
//    Because w is decoded from state only, it is glitch-free.
//  - Relative timing: for the same stimulus, the Moore w is the Mealy w delayed by one clock.
//  - Input handling: j is treated as synchronous to clk; no synchronizer is included.
//  - Encoding: binary state register, 3 bits.
//    Unreachable codes (6, 7, and 5 in Mealy) transition to S0 with w=0.
// CONFIGURATION
//  - SEQ_DET_COUNT_EN defined:
//    Adds the count port and a CNT_W-bit register.
//    count increments on each posedge clk where a detect is committed:
//    - Mealy: (state==S4 & ~j).
//    - Moore: next state == S5.
//    count saturates at all-ones, does not wrap, and is cleared by rst.
//  - SEQ_DET_COUNT_EN undefined: no count port and no counter logic; w behaviour is identical.
// TESTING
//  - Reset: hold rst=0 for 10 ns mid-stream -> w=0 immediately, state S0; after release, the stream restarts clean.
//  - Single match: j=1,0,0,1,0 on successive edges -> Mealy w=1 in the cycle the final 0 is driven; Moore w=1 for the following cycle; count=1.
//  - Overlap: j=1,0,0,1,0,0,1,0 with OVERLAP=1 -> two detects (after bits 5 and 8); with OVERLAP=0 -> one detect; count=2 / 1.
//  - Near-miss: j=1,0,0,1,1,0,0,1,1 -> w stays 0 throughout; state returns to S1 after each trailing 1.
//  - Mealy/Moore equivalence: drive both styles with a random 200-bit stream -> Moore w equals Mealy w delayed by one clock on every cycle.
//  - Saturation (CNT_W=2): drive 5 matches -> count reads 1,2,3,3,3.

Source files
------------

// File: rtl/seq_det_10010.sv
// seq_det_10010 -- serial "10010" sequence detector.
// MOORE selects Moore (6 states, registered-state output) or Mealy (5 states)
// style; OVERLAP selects whether the matched suffix is reused after a detect.
// Define SEQ_DET_COUNT_EN to add the CNT_W parameter and the saturating
// detection counter on port count.
module seq_det_10010 #(
   parameter bit MOORE   = 1'b1,
   parameter bit OVERLAP = 1'b1
`ifdef SEQ_DET_COUNT_EN
   ,
   parameter int unsigned CNT_W = 8
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             j,
   output logic             w
`ifdef SEQ_DET_COUNT_EN
   ,
   output logic [CNT_W-1:0] count
`endif
);

   // Each state is named after the longest prefix of "10010" matched so far.
   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5
   } state_t;

   state_t state_q, state_d;

   // State register; reset is asynchronous and discards any partial match.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S0;
      else      state_q <= state_d;
   end

   // Next-state decode; unreachable codes fall back to S0.
   always_comb begin
      state_d = S0;
      case (state_q)
         S0: state_d = j ? S1 : S0;
         S1: state_d = j ? S1 : S2;
         S2: state_d = j ? S1 : S3;
         S3: state_d = j ? S4 : S0;
         S4: begin
            if (j)          state_d = S1;
            else if (MOORE) state_d = S5;
            else            state_d = OVERLAP ? S2 : S0;
         end
         // S5 only exists in Moore; with overlap it acts as "10" for the next bit.
         S5: begin
            if (!MOORE) state_d = S0;
            else if (j) state_d = S1;
            else        state_d = OVERLAP ? S3 : S0;
         end
         default: state_d = S0;
      endcase
   end

   // Detect flag: Moore decodes state only, Mealy also looks at the live input.
   always_comb begin
      w = 1'b0;
      if (MOORE) w = (state_q == S5);
      else       w = (state_q == S4) && !j;
   end

`ifdef SEQ_DET_COUNT_EN
   logic             det_commit;
   logic [CNT_W-1:0] count_q;

   // A detect is committed on the edge that completes the sequence.
   always_comb begin
      det_commit = 1'b0;
      if (MOORE) det_commit = (state_d == S5);
      else       det_commit = (state_q == S4) && !j;
   end

   // Saturating detection counter; holds at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               count_q <= '0;
      else if (det_commit && (count_q != '1)) count_q <= count_q + CNT_W'(1);
   end

   assign count = count_q;
`endif

endmodule

// File: tb/tb_seq_det_10010.sv
// Testbench for seq_det_10010: four instances (Mealy/Moore x overlap/no-overlap)
// share one input stream. With SEQ_DET_COUNT_EN the overlapping instances use
// CNT_W=2 to exercise saturation, the others keep the default width.
module tb_seq_det_10010;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic j   = 1'b0;
   logic w_mealy_ov, w_moore_ov, w_mealy_no, w_moore_no;
`ifdef SEQ_DET_COUNT_EN
   logic [1:0] c_mealy_ov, c_moore_ov;
   logic [7:0] c_mealy_no, c_moore_no;
`endif

   always #5 clk = ~clk;

   seq_det_10010 #(.MOORE(1'b0), .OVERLAP(1'b1)
`ifdef SEQ_DET_COUNT_EN
      , .CNT_W(2)
`endif
   ) u_mealy_ov (.clk(clk), .rst(rst), .j(j), .w(w_mealy_ov)
`ifdef SEQ_DET_COUNT_EN
      , .count(c_mealy_ov)
`endif
   );

   seq_det_10010 #(.MOORE(1'b1), .OVERLAP(1'b1)
`ifdef SEQ_DET_COUNT_EN
      , .CNT_W(2)
`endif
   ) u_moore_ov (.clk(clk), .rst(rst), .j(j), .w(w_moore_ov)
`ifdef SEQ_DET_COUNT_EN
      , .count(c_moore_ov)
`endif
   );

   seq_det_10010 #(.MOORE(1'b0), .OVERLAP(1'b0)) u_mealy_no (
      .clk(clk), .rst(rst), .j(j), .w(w_mealy_no)
`ifdef SEQ_DET_COUNT_EN
      , .count(c_mealy_no)
`endif
   );

   seq_det_10010 #(.MOORE(1'b1), .OVERLAP(1'b0)) u_moore_no (
      .clk(clk), .rst(rst), .j(j), .w(w_moore_no)
`ifdef SEQ_DET_COUNT_EN
      , .count(c_moore_no)
`endif
   );

   typedef struct {
      logic       w_mealy_ov;
      logic       w_moore_ov;
      logic       w_mealy_no;
      logic       w_moore_no;
      logic [7:0] c_ov;
      logic [7:0] c_no;
   } exp_t;

   exp_t q[$];
   int   nchecks = 0;
   int   nerr    = 0;

   // Expected-value state built from the hand-computed Mealy expectations.
   logic       prev_ov, prev_no;
   logic [7:0] cnt_ov, cnt_no;
   // Window model used for the random stream.
   logic [3:0] hist_ov, hist_no;
   int         len_ov, len_no;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic clear_model();
      prev_ov = 1'b0; prev_no = 1'b0;
      cnt_ov  = '0;   cnt_no  = '0;
      hist_ov = '0;   hist_no = '0;
      len_ov  = 0;    len_no  = 0;
   endtask

   // One clock of stimulus; eov/eno are the expected Mealy flags for this cycle.
   task automatic step(input logic jb, input logic eov, input logic eno);
      exp_t r;
      @(posedge clk); #1;
      rst = 1'b1;
      j   = jb;
      r.w_mealy_ov = eov;
      r.w_moore_ov = prev_ov;
      r.w_mealy_no = eno;
      r.w_moore_no = prev_no;
      r.c_ov = cnt_ov;
      r.c_no = cnt_no;
      q.push_back(r);
      prev_ov = eov;
      prev_no = eno;
      if (eov && cnt_ov != 8'd3)   cnt_ov = cnt_ov + 8'd1;
      if (eno && cnt_no != 8'd255) cnt_no = cnt_no + 8'd1;
   endtask

   // Assert reset between edges for one full period and check it acts at once.
   task automatic do_reset();
      exp_t r;
      @(posedge clk); #1;
      rst = 1'b0;
      j   = 1'b0;
      #1;
      chk("rst_now_mealy_ov", {7'd0, w_mealy_ov}, 8'd0);
      chk("rst_now_moore_ov", {7'd0, w_moore_ov}, 8'd0);
      chk("rst_now_mealy_no", {7'd0, w_mealy_no}, 8'd0);
      chk("rst_now_moore_no", {7'd0, w_moore_no}, 8'd0);
      r.w_mealy_ov = 1'b0; r.w_moore_ov = 1'b0;
      r.w_mealy_no = 1'b0; r.w_moore_no = 1'b0;
      r.c_ov = '0; r.c_no = '0;
      q.push_back(r);
      clear_model();
   endtask

   task automatic run_vec(input string bits, input string e_ov, input string e_no);
      for (int i = 0; i < bits.len(); i++)
         step(bits[i] == 8'h31, e_ov[i] == 8'h31, e_no[i] == 8'h31);
   endtask

   // Reference: last five bits since (re)start equal 10010; no-overlap restarts after a hit.
   task automatic model(input logic jb, output logic eov, output logic eno);
      eov = (len_ov >= 4) && ({hist_ov, jb} == 5'b10010);
      eno = (len_no >= 4) && ({hist_no, jb} == 5'b10010);
      hist_ov = {hist_ov[2:0], jb};
      len_ov++;
      if (eno) begin
         hist_no = '0;
         len_no  = 0;
      end else begin
         hist_no = {hist_no[2:0], jb};
         len_no++;
      end
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t r;
         r = q.pop_front();
         chk("w_mealy_ov", {7'd0, w_mealy_ov}, {7'd0, r.w_mealy_ov});
         chk("w_moore_ov", {7'd0, w_moore_ov}, {7'd0, r.w_moore_ov});
         chk("w_mealy_no", {7'd0, w_mealy_no}, {7'd0, r.w_mealy_no});
         chk("w_moore_no", {7'd0, w_moore_no}, {7'd0, r.w_moore_no});
`ifdef SEQ_DET_COUNT_EN
         chk("count_mealy_ov", {6'd0, c_mealy_ov}, r.c_ov);
         chk("count_moore_ov", {6'd0, c_moore_ov}, r.c_ov);
         chk("count_mealy_no", c_mealy_no, r.c_no);
         chk("count_moore_no", c_moore_no, r.c_no);
`endif
      end
   end

   initial begin
      logic jb, eov, eno;
      clear_model();
      #2;
      chk("reset_w_mealy_ov", {7'd0, w_mealy_ov}, 8'd0);
      chk("reset_w_moore_ov", {7'd0, w_moore_ov}, 8'd0);
      chk("reset_w_mealy_no", {7'd0, w_mealy_no}, 8'd0);
      chk("reset_w_moore_no", {7'd0, w_moore_no}, 8'd0);
`ifdef SEQ_DET_COUNT_EN
      chk("reset_count_ov", {6'd0, c_mealy_ov}, 8'd0);
      chk("reset_count_no", c_moore_no, 8'd0);
`endif

      // Single match, one trailing bit so the Moore flag is observed.
      run_vec("100100", "000010", "000010");

      // Overlap: two hits with suffix reuse, one without.
      do_reset();
      run_vec("100100100", "000010010", "000010000");

      // Near-miss: never a detect.
      do_reset();
      run_vec("1001100110", "0000000000", "0000000000");

      // Five back-to-back matches: 2-bit counters saturate at 3.
      do_reset();
      run_vec("100101001010010100101001000", "000010000100001000010000100", "000010000100001000010000100");

      // Reset while the Moore flag is up, then a tail that would only match
      // if the old partial state survived.
      do_reset();
      run_vec("10010", "00001", "00001");
      do_reset();
      run_vec("010", "000", "000");

      // Random stream checked against the window model.
      do_reset();
      for (int i = 0; i < 200; i++) begin
         jb = 1'($urandom_range(0, 1));
         model(jb, eov, eno);
         step(jb, eov, eno);
      end
      step(1'b0, 1'b0, 1'b0);

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         nchecks++;
         nerr++;
         $display("FAIL drain: %0d records left, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
      $finish;
   end

endmodule
